// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared definitions for the write-back stage and its register file:
//   default bus widths, the zero-register index and the read-source
//   classification used by both combinational read ports.
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

  // Default geometry of the architectural register file.
  localparam int DATA_W       = 32;  // register data bus width
  localparam int ADDR_W       = 5;   // register address bus width
  localparam int REG_NUM      = 32;  // number of architectural registers
  localparam int CNT_W        = 32;  // commit counter width
  localparam int ZERO_REG_IDX = 0;   // hard-wired zero register index
  localparam bit TRUE         = 1'b1;

  // Where a read port takes its value from.
  typedef enum logic [1:0] {
    RD_ZERO,    // hard-wired zero register
    RD_BYPASS,  // value being written back this cycle
    RD_STORE    // value held in the register array
  } rd_src_e;

  // Priority: zero register, then same-cycle write, then storage.
  function automatic rd_src_e read_src(input logic addr_is_zero_reg,
                                       input logic we,
                                       input logic addr_hits_des);
    if (addr_is_zero_reg)        return RD_ZERO;
    else if (we && addr_hits_des) return RD_BYPASS;
    else                          return RD_STORE;
  endfunction

endpackage

// File: rtl/wb_regfile_reg_array.sv
// -----------------------------------------------------------------------------
// wb_regfile_reg_array
//   RegNum x DataW register storage with a synchronous reset, one write port
//   and two raw asynchronous read ports. No bypass or zero-register logic
//   lives here; the raw stored value is always returned.
//
// Ports
//   clk      in   clock, writes and reset on posedge
//   rst      in   synchronous active-high reset, clears every entry
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr_a  in   read port A address
//   raddr_b  in   read port B address
//   rdata_a  out  read port A raw data
//   rdata_b  out  read port B raw data
// -----------------------------------------------------------------------------
module wb_regfile_reg_array
  import wb_regfile_pkg::*;
#(
  parameter int DataW  = DATA_W,
  parameter int AddrW  = ADDR_W,
  parameter int RegNum = REG_NUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [DataW-1:0] wdata,
  input  logic [AddrW-1:0] raddr_a,
  input  logic [AddrW-1:0] raddr_b,
  output logic [DataW-1:0] rdata_a,
  output logic [DataW-1:0] rdata_b
);

  logic [DataW-1:0] mem [RegNum];

  // Addresses beyond RegNum (when RegNum < 2**AddrW) neither write nor read.
  logic waddr_ok;
  logic raddr_a_ok;
  logic raddr_b_ok;

  assign waddr_ok   = int'(waddr)   < RegNum;
  assign raddr_a_ok = int'(raddr_a) < RegNum;
  assign raddr_b_ok = int'(raddr_b) < RegNum;

  // NOTE: this storage is deliberately reset, because the architecture
  // guarantees every register reads 0 after reset; that costs a reset net on
  // every flop, so do not copy the pattern into plain data RAMs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RegNum; i++) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        mem[i] <= '0;
      end
    end else if (we && waddr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = raddr_a_ok ? mem[raddr_a] : '0;
  assign rdata_b = raddr_b_ok ? mem[raddr_b] : '0;

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage plus architectural register file. Selects the
//   write-back value from the registered MEM outputs, commits it to the
//   register array, serves two combinational ID read ports with a
//   write-first bypass, exports the write-back bundle to the forwarding unit
//   and counts committed writes.
//
// Ports
//   clk             in   clock, all state updates on posedge
//   rst             in   synchronous active-high reset
//   w_write_reg_i   in   write-reg flag from MEM
//   w_mem_to_reg_i  in   1 = load data, 0 = ALU result
//   data_from_mem   in   load data from MEM
//   alu_result_i    in   ALU result from MEM
//   w_des_r_i       in   destination register
//   rs_addr         in   read port A address
//   rt_addr         in   read port B address
//   rs_data         out  read port A data
//   rt_data         out  read port B data
//   wb_write_reg_o  out  effective write enable, for forwarding
//   wb_des_r_o      out  write-back destination, for forwarding
//   wb_data_o       out  selected write-back value, for forwarding
//   commit_cnt      out  number of committed register writes (wraps)
// -----------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DataW   = DATA_W,
  parameter int AddrW   = ADDR_W,
  parameter int RegNum  = REG_NUM,
  parameter bit ZeroReg = TRUE,
  parameter int CntW    = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_write_reg_i,
  input  logic             w_mem_to_reg_i,
  input  logic [DataW-1:0] data_from_mem,
  input  logic [DataW-1:0] alu_result_i,
  input  logic [AddrW-1:0] w_des_r_i,
  input  logic [AddrW-1:0] rs_addr,
  input  logic [AddrW-1:0] rt_addr,
  output logic [DataW-1:0] rs_data,
  output logic [DataW-1:0] rt_data,
  output logic             wb_write_reg_o,
  output logic [AddrW-1:0] wb_des_r_o,
  output logic [DataW-1:0] wb_data_o,
  output logic [CntW-1:0]  commit_cnt
);

  localparam logic [AddrW-1:0] ZeroAddr = AddrW'(ZERO_REG_IDX);

  logic             we;
  logic             des_is_zero_reg;
  logic [DataW-1:0] wb_data;
  logic [DataW-1:0] raw_rs;
  logic [DataW-1:0] raw_rt;
  logic [CntW-1:0]  cnt_q;

  // ---------------------------------------------------------------------------
  // Write-back selection and effective write enable
  // ---------------------------------------------------------------------------
  assign wb_data = w_mem_to_reg_i ? data_from_mem : alu_result_i;

  assign des_is_zero_reg = (ZeroReg == TRUE) && (w_des_r_i == ZeroAddr);

  // Reset masks the write so a write pending at the reset edge is neither
  // bypassed, stored nor counted.
  assign we = w_write_reg_i & ~rst & ~des_is_zero_reg;

  assign wb_data_o      = wb_data;
  assign wb_des_r_o     = w_des_r_i;
  assign wb_write_reg_o = we;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  wb_regfile_reg_array #(
    .DataW  (DataW),
    .AddrW  (AddrW),
    .RegNum (RegNum)
  ) u_reg_array (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (w_des_r_i),
    .wdata   (wb_data),
    .raddr_a (rs_addr),
    .raddr_b (rt_addr),
    .rdata_a (raw_rs),
    .rdata_b (raw_rt)
  );

  // ---------------------------------------------------------------------------
  // Read ports: zero register, then write-first bypass, then storage.
  // Each port resolves independently, so both may bypass at once.
  // ---------------------------------------------------------------------------
  function automatic logic [DataW-1:0] resolve_read(input logic [AddrW-1:0] addr,
                                                    input logic [DataW-1:0] raw);
    rd_src_e src;
    src = read_src((ZeroReg == TRUE) && (addr == ZeroAddr), we, addr == w_des_r_i);
    case (src)
      RD_ZERO:   return '0;
      RD_BYPASS: return wb_data;
      default:   return raw;
    endcase
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets an unconditional assignment on every
    // path; a path that skips one would infer a latch.
    rs_data = resolve_read(rs_addr, raw_rs);
    rt_data = resolve_read(rt_addr, raw_rt);
  end

  // ---------------------------------------------------------------------------
  // Commit counter: wraps naturally at 2**CntW.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (we) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile (ZeroReg=1, CntW=4). Inputs are driven
//   just after the falling edge, outputs are compared 1 ns later; the
//   reference model (array of register values plus a commit count) is
//   updated at the rising edge from the stimulus the bench applied.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_write_reg_i;
  logic          w_mem_to_reg_i;
  logic [DW-1:0] data_from_mem;
  logic [DW-1:0] alu_result_i;
  logic [AW-1:0] w_des_r_i;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          wb_write_reg_o;
  logic [AW-1:0] wb_des_r_o;
  logic [DW-1:0] wb_data_o;
  logic [CW-1:0] commit_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: architectural register contents and commit count.
  logic [DW-1:0] model_regs [32];
  int unsigned   model_cnt;

  always #5 clk = ~clk;

  wb_regfile #(
    .DataW   (DW),
    .AddrW   (AW),
    .RegNum  (32),
    .ZeroReg (1'b1),
    .CntW    (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .w_write_reg_i  (w_write_reg_i),
    .w_mem_to_reg_i (w_mem_to_reg_i),
    .data_from_mem  (data_from_mem),
    .alu_result_i   (alu_result_i),
    .w_des_r_i      (w_des_r_i),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .wb_write_reg_o (wb_write_reg_o),
    .wb_des_r_o     (wb_des_r_o),
    .wb_data_o      (wb_data_o),
    .commit_cnt     (commit_cnt)
  );

  // ---------------------------------------------------------------------------
  // Model helpers, derived from the applied stimulus only
  // ---------------------------------------------------------------------------
  function automatic logic [DW-1:0] exp_wb();
    return w_mem_to_reg_i ? data_from_mem : alu_result_i;
  endfunction

  function automatic logic exp_we();
    return (w_write_reg_i === 1'b1) && (rst === 1'b0) && (w_des_r_i != 0);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (exp_we() && a == w_des_r_i) return exp_wb();
    return model_regs[a];
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
    return CW'(model_cnt % 16);
  endfunction

  task automatic drive(input logic wr, input logic mtr,
                       input logic [DW-1:0] mem, input logic [DW-1:0] alu,
                       input logic [AW-1:0] des, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input logic r);
    w_write_reg_i  = wr;
    w_mem_to_reg_i = mtr;
    data_from_mem  = mem;
    alu_result_i   = alu;
    w_des_r_i      = des;
    rs_addr        = ra;
    rt_addr        = rb;
    rst            = r;
  endtask

  // One rising edge: update the model as the architecture dictates, then
  // return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst === 1'b1) begin
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      model_cnt = 0;
    end else if (exp_we()) begin
      model_regs[w_des_r_i] = exp_wb();
      model_cnt = model_cnt + 1;
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h0, 32'h0000_00AB, 5'd3, 5'd1, 5'd2, 1'b1);
    #1;
    if (wb_write_reg_o !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", wb_write_reg_o); end
    vectors++;
    if (wb_des_r_o !== 5'd3) begin miscompares++; $display("FAIL reset_des got %0d want 3", wb_des_r_o); end
    vectors++;
    if (wb_data_o !== 32'h0000_00AB) begin miscompares++; $display("FAIL reset_data got %h want 000000ab", wb_data_o); end
    vectors++;
    tick();
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    if (commit_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", commit_cnt); end
    vectors++;
    for (int i = 0; i < 16; i++) begin
      rs_addr = AW'(2 * i);
      rt_addr = AW'(2 * i + 1);
      #1;
      if (rs_data !== 32'h0) begin miscompares++; $display("FAIL reset_rs r%0d got %h want 0", rs_addr, rs_data); end
      vectors++;
      if (rt_data !== 32'h0) begin miscompares++; $display("FAIL reset_rt r%0d got %h want 0", rt_addr, rt_data); end
      vectors++;
    end
  endtask

  task automatic test_alu_wb();
    drive(1'b1, 1'b0, 32'h5555_5555, 32'h0000_1234, 5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    if (wb_data_o !== 32'h0000_1234) begin miscompares++; $display("FAIL alu_wbdata got %h want 00001234", wb_data_o); end
    vectors++;
    if (wb_write_reg_o !== 1'b1) begin miscompares++; $display("FAIL alu_we got %b want 1", wb_write_reg_o); end
    vectors++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0, 1'b0);
    #1;
    if (rs_data !== 32'h0000_1234) begin miscompares++; $display("FAIL alu_rs got %h want 00001234", rs_data); end
    vectors++;
    if (commit_cnt !== 4'd1) begin miscompares++; $display("FAIL alu_cnt got %0d want 1", commit_cnt); end
    vectors++;
  endtask

  task automatic test_load_wb();
    drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0010, 5'd7, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7, 1'b0);
    #1;
    if (rt_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL load_rt got %h want deadbeef", rt_data); end
    vectors++;
    if (commit_cnt !== exp_cnt()) begin miscompares++; $display("FAIL load_cnt got %0d want %0d", commit_cnt, exp_cnt()); end
    vectors++;
  endtask

  task automatic test_r0();
    logic [CW-1:0] cnt_before;
    cnt_before = exp_cnt();
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    if (wb_write_reg_o !== 1'b0) begin miscompares++; $display("FAIL r0_we got %b want 0", wb_write_reg_o); end
    vectors++;
    if (rs_data !== 32'h0) begin miscompares++; $display("FAIL r0_bypass got %h want 0", rs_data); end
    vectors++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    if (rs_data !== 32'h0) begin miscompares++; $display("FAIL r0_read got %h want 0", rs_data); end
    vectors++;
    if (commit_cnt !== cnt_before) begin miscompares++; $display("FAIL r0_cnt got %0d want %0d", commit_cnt, cnt_before); end
    vectors++;
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0001, 5'd3, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0002, 5'd3, 5'd3, 5'd3, 1'b0);
    #1;
    if (rs_data !== 32'h2) begin miscompares++; $display("FAIL byp_rs_pre got %h want 2", rs_data); end
    vectors++;
    if (rt_data !== 32'h2) begin miscompares++; $display("FAIL byp_rt_pre got %h want 2", rt_data); end
    vectors++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3, 1'b0);
    #1;
    if (rs_data !== 32'h2) begin miscompares++; $display("FAIL byp_rs_post got %h want 2", rs_data); end
    vectors++;
    if (rt_data !== 32'h2) begin miscompares++; $display("FAIL byp_rt_post got %h want 2", rt_data); end
    vectors++;
  endtask

  task automatic test_bubble_reset();
    logic [DW-1:0] r4;
    // Known value in r4 and r9 first.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_4444, 5'd4, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h0000_9999, 32'h0, 5'd9, 5'd0, 5'd0, 1'b0);
    tick();
    r4 = model_regs[4];
    // Bubble with a live-looking payload, then a bubble with X data.
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0099, 5'd4, 5'd4, 5'd0, 1'b0);
    #1;
    if (wb_write_reg_o !== 1'b0) begin miscompares++; $display("FAIL bubble_we got %b want 0", wb_write_reg_o); end
    vectors++;
    if (rs_data !== r4) begin miscompares++; $display("FAIL bubble_nobyp got %h want %h", rs_data, r4); end
    vectors++;
    tick();
    drive(1'b0, 1'bx, 'x, 'x, 5'd4, 5'd4, 5'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0, 1'b0);
    #1;
    if (rs_data !== r4) begin miscompares++; $display("FAIL bubble_r4 got %h want %h", rs_data, r4); end
    vectors++;
    // Reset together with a write: stored value visible, write lost.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd9, 5'd9, 5'd4, 1'b1);
    #1;
    if (wb_write_reg_o !== 1'b0) begin miscompares++; $display("FAIL rstwr_we got %b want 0", wb_write_reg_o); end
    vectors++;
    if (rs_data !== 32'h0000_9999) begin miscompares++; $display("FAIL rstwr_nobyp got %h want 00009999", rs_data); end
    vectors++;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd4, 1'b0);
    #1;
    if (rs_data !== 32'h0) begin miscompares++; $display("FAIL rstwr_r9 got %h want 0", rs_data); end
    vectors++;
    if (rt_data !== 32'h0) begin miscompares++; $display("FAIL rstwr_r4 got %h want 0", rt_data); end
    vectors++;
    if (commit_cnt !== 4'd0) begin miscompares++; $display("FAIL rstwr_cnt got %0d want 0", commit_cnt); end
    vectors++;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
    tick();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'(i), AW'(1 + (i % 31)), 5'd0, 5'd0, 1'b0);
      tick();
      #1;
      if (commit_cnt !== CW'(i % 16)) begin
        miscompares++;
        $display("FAIL wrap_cnt write %0d got %0d want %0d", i, commit_cnt, i % 16);
      end
      vectors++;
    end
  endtask

  task automatic test_random();
    logic          wr, mtr, r;
    logic [AW-1:0] des, ra, rb;
    for (int n = 0; n < 400; n++) begin
      wr  = ($urandom_range(0, 3) != 0);
      mtr = $urandom_range(0, 1) == 1;
      r   = ($urandom_range(0, 31) == 0);
      des = AW'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 2) == 0) ? des : AW'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 2) == 0) ? des : AW'($urandom_range(0, 31));
      drive(wr, mtr, $urandom, $urandom, des, ra, rb, r);
      #1;
      if (wb_data_o !== exp_wb()) begin miscompares++; $display("FAIL rnd_wbdata n=%0d got %h want %h", n, wb_data_o, exp_wb()); end
      vectors++;
      if (wb_des_r_o !== des) begin miscompares++; $display("FAIL rnd_des n=%0d got %0d want %0d", n, wb_des_r_o, des); end
      vectors++;
      if (wb_write_reg_o !== exp_we()) begin miscompares++; $display("FAIL rnd_we n=%0d got %b want %b", n, wb_write_reg_o, exp_we()); end
      vectors++;
      if (rs_data !== exp_read(ra)) begin miscompares++; $display("FAIL rnd_rs n=%0d r%0d got %h want %h", n, ra, rs_data, exp_read(ra)); end
      vectors++;
      if (rt_data !== exp_read(rb)) begin miscompares++; $display("FAIL rnd_rt n=%0d r%0d got %h want %h", n, rb, rt_data, exp_read(rb)); end
      vectors++;
      tick();
      #1;
      if (commit_cnt !== exp_cnt()) begin miscompares++; $display("FAIL rnd_cnt n=%0d got %0d want %0d", n, commit_cnt, exp_cnt()); end
      vectors++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_cnt = 0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1);
    @(negedge clk);
    test_reset();
    test_alu_wb();
    test_load_wb();
    test_r0();
    test_bypass();
    test_bubble_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
